multicycle_control32: RTL and testbench

Multi-cycle control unit for the 32-bit RISC-V core; it generalises the single-cycle decoder into a sequenced FSM. It splits every instruction into fetch / decode / execute / memory / I/O / write-back steps, and waits on memory and I/O handshakes. It gates I/O on `ecall` only, choosing read or write from the a7 service code through parameterised ranges, and counts retired instructions. It sits between instruction memory, register file, ALU, data memory and the I/O bridge.

---
 rtl/multicycle_control32.sv | 274 +++++++++++++++++++++++++++
 tb/tb_multicycle_control32.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control32.sv
// Multi-cycle control FSM for the RV32 core: sequences fetch/decode/execute/memory/IO/write-back,
// waits on memory and I/O handshakes, and counts retired instructions.
module multicycle_control32 #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IO_RD_LO = 0,
  parameter int unsigned IO_RD_HI = 3,
  parameter int unsigned IO_WR_LO = 4,
  parameter int unsigned IO_WR_HI = 5,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [31:0]      Instruction,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  rega7,
  input  logic             mem_ready,
  input  logic             io_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IORead,
  output logic             IOWrite,
  output logic             MemorIOtoReg,
  output logic             Jr,
  output logic             Jal,
  output logic             Branch,
  output logic             I_format,
  output logic             Sftmd,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StIo     = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch, ClsEcall} cls_e;
  typedef enum logic [1:0] {IoNone, IoRead, IoWrite} io_kind_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Offset-and-span range test avoids constant comparisons when a bound is zero.
  localparam logic [XLEN-1:0] RdLo   = XLEN'(IO_RD_LO);
  localparam logic [XLEN-1:0] RdSpan = XLEN'(IO_RD_HI - IO_RD_LO);
  localparam logic [XLEN-1:0] WrLo   = XLEN'(IO_WR_LO);
  localparam logic [XLEN-1:0] WrSpan = XLEN'(IO_WR_HI - IO_WR_LO);
  localparam bit              RdEn   = (IO_RD_HI >= IO_RD_LO);
  localparam bit              WrEn   = (IO_WR_HI >= IO_WR_LO);

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  cls_e             cls_q;
  io_kind_e         io_kind_q;
  logic [1:0]       alu_op_q;
  logic             alu_src_q, sftmd_q, i_format_q, jal_q, jr_q, branch_q, m2r_q;
  logic [CNT_W-1:0] instret_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a7_rd_off, a7_wr_off;
  logic            a7_in_rd, a7_in_wr;
  io_kind_e        io_kind_d;
  cls_e            dec_cls;
  logic            dec_legal;
  logic [1:0]      dec_alu_op;
  logic            dec_alu_src, dec_sftmd, dec_i_format, dec_jal, dec_jr, dec_branch, dec_m2r;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign a7_rd_off = rega7 - RdLo;
  assign a7_wr_off = rega7 - WrLo;
  assign a7_in_rd  = RdEn && (a7_rd_off <= RdSpan);
  assign a7_in_wr  = WrEn && (a7_wr_off <= WrSpan);

  always_comb begin
    io_kind_d = IoNone;
    if (a7_in_rd) begin
      io_kind_d = IoRead;
    end else if (a7_in_wr) begin
      io_kind_d = IoWrite;
    end
  end

  always_comb begin
    dec_cls      = ClsAlu;
    dec_legal    = 1'b1;
    dec_alu_op   = 2'b00;
    dec_alu_src  = 1'b1;
    dec_sftmd    = 1'b0;
    dec_i_format = 1'b0;
    dec_jal      = 1'b0;
    dec_jr       = 1'b0;
    dec_branch   = 1'b0;
    dec_m2r      = 1'b0;
    case (opcode)
      OpR: begin
        dec_alu_op  = 2'b10;
        dec_alu_src = 1'b0;
        dec_sftmd   = (funct3 == 3'd1) || (funct3 == 3'd5);
      end
      OpIAlu: begin
        dec_alu_op   = 2'b11;
        dec_i_format = 1'b1;
        dec_sftmd    = (funct3 == 3'd1) || (funct3 == 3'd5);
      end
      OpLoad: begin
        dec_cls      = ClsLoad;
        dec_i_format = 1'b1;
        dec_m2r      = 1'b1;
      end
      OpStore: dec_cls = ClsStore;
      OpBranch: begin
        dec_cls     = ClsBranch;
        dec_alu_op  = 2'b01;
        dec_alu_src = 1'b0;
        dec_branch  = 1'b1;
      end
      OpJal:   dec_jal = 1'b1;
      OpJalr:  dec_jr  = 1'b1;
      OpLui, OpAuipc: ;
      OpSystem: begin
        dec_cls   = ClsEcall;
        dec_legal = (ir_q[31:7] == 25'd0);
        dec_m2r   = (io_kind_d == IoRead);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_write = 1'b0;
    pc_write = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IORead   = 1'b0;
    IOWrite  = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (instr_valid) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: state_d = dec_legal ? StExec : StHalt;
      StExec: begin
        case (cls_q)
          ClsLoad, ClsStore: state_d = StMem;
          ClsEcall: begin
            if (io_kind_q == IoNone) begin
              pc_write = 1'b1;
              state_d  = StFetch;
            end else begin
              state_d = StIo;
            end
          end
          ClsBranch: begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        MemRead  = (cls_q == ClsLoad);
        MemWrite = (cls_q == ClsStore);
        if (mem_ready) begin
          if (cls_q == ClsLoad) begin
            state_d = StWb;
          end else begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StIo: begin
        IORead  = (io_kind_q == IoRead);
        IOWrite = (io_kind_q == IoWrite);
        if (io_ack) begin
          if (io_kind_q == IoRead) begin
            state_d = StWb;
          end else begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      instret_q <= '0;
      ir_q      <= '0;
    end else begin
      state_q <= state_d;
      if (pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (ir_write) begin
        ir_q <= Instruction;
      end
    end
  end

  // Decode results persist until the next instruction is decoded.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cls_q      <= ClsAlu;
      io_kind_q  <= IoNone;
      alu_op_q   <= 2'b00;
      alu_src_q  <= 1'b0;
      sftmd_q    <= 1'b0;
      i_format_q <= 1'b0;
      jal_q      <= 1'b0;
      jr_q       <= 1'b0;
      branch_q   <= 1'b0;
      m2r_q      <= 1'b0;
    end else if ((state_q == StDecode) && dec_legal) begin
      cls_q      <= dec_cls;
      io_kind_q  <= io_kind_d;
      alu_op_q   <= dec_alu_op;
      alu_src_q  <= dec_alu_src;
      sftmd_q    <= dec_sftmd;
      i_format_q <= dec_i_format;
      jal_q      <= dec_jal;
      jr_q       <= dec_jr;
      branch_q   <= dec_branch;
      m2r_q      <= dec_m2r;
    end
  end

  assign MemorIOtoReg = m2r_q;
  assign Jr           = jr_q;
  assign Jal          = jal_q;
  assign Branch       = branch_q;
  assign I_format     = i_format_q;
  assign Sftmd        = sftmd_q;
  assign ALUSrc       = alu_src_q;
  assign ALUOp        = alu_op_q;
  assign illegal      = (state_q == StHalt);
  assign state        = state_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_control32.sv
// Scoreboard bench for multicycle_control32: the driver queues hand-computed expectations per
// instruction and a monitor checks them whenever the DUT retires one with pc_write.
module tb_multicycle_control32;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] rega7;
  logic        mem_ready, io_ack;
  logic        ir_write, pc_write, RegWrite, MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg;
  logic        Jr, Jal, Branch, I_format, Sftmd, ALUSrc, illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_control32 dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .Instruction  (Instruction),
    .instr_valid  (instr_valid),
    .rega7        (rega7),
    .mem_ready    (mem_ready),
    .io_ack       (io_ack),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IORead       (IORead),
    .IOWrite      (IOWrite),
    .MemorIOtoReg (MemorIOtoReg),
    .Jr           (Jr),
    .Jal          (Jal),
    .Branch       (Branch),
    .I_format     (I_format),
    .Sftmd        (Sftmd),
    .ALUSrc       (ALUSrc),
    .ALUOp        (ALUOp),
    .illegal      (illegal),
    .state        (state),
    .instret      (instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lat;
    int st;
    int rw;
    int m2r;
    int aluop;
    int alusrc;
    int sftmd;
    int ifmt;
    int jal;
    int jr;
    int br;
    int mrd;
    int mwr;
    int ird;
    int iwr;
    int ret;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ret = 0;
  int   mon_idx = 0;
  bit   active = 0;
  int   cyc, c_mrd, c_mwr, c_ird, c_iwr, c_rw;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(int lat, int st, int rw, int m2r, int aluop, int alusrc,
                              int sftmd, int ifmt, int jal, int jr, int br,
                              int mrd, int mwr, int ird, int iwr);
    exp_t e;
    e.lat = lat; e.st = st; e.rw = rw; e.m2r = m2r; e.aluop = aluop; e.alusrc = alusrc;
    e.sftmd = sftmd; e.ifmt = ifmt; e.jal = jal; e.jr = jr; e.br = br;
    e.mrd = mrd; e.mwr = mwr; e.ird = ird; e.iwr = iwr; e.ret = 0;
    return e;
  endfunction

  // Monitor: sample 1ns after the falling edge so driver updates have settled.
  always @(negedge clock) begin
    #1;
    if (rst_n) begin
      if (ir_write) begin
        active = 1; cyc = 1;
        c_mrd = 0; c_mwr = 0; c_ird = 0; c_iwr = 0; c_rw = 0;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        c_mrd += int'(MemRead); c_mwr += int'(MemWrite);
        c_ird += int'(IORead);  c_iwr += int'(IOWrite);
        c_rw  += int'(RegWrite);
      end
      if (pc_write) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pc_write: got pc_write=1 in state %0d, expected none", state);
        end else begin
          exp_t e;
          string p;
          e = sb.pop_front();
          p = $sformatf("i%0d.", mon_idx);
          check({p, "latency"}, cyc, e.lat);
          check({p, "state"}, state, e.st);
          check({p, "RegWrite"}, RegWrite, e.rw);
          check({p, "RegWrite_cycles"}, c_rw, e.rw);
          check({p, "MemorIOtoReg"}, MemorIOtoReg, e.m2r);
          check({p, "ALUOp"}, ALUOp, e.aluop);
          check({p, "ALUSrc"}, ALUSrc, e.alusrc);
          check({p, "Sftmd"}, Sftmd, e.sftmd);
          check({p, "I_format"}, I_format, e.ifmt);
          check({p, "Jal"}, Jal, e.jal);
          check({p, "Jr"}, Jr, e.jr);
          check({p, "Branch"}, Branch, e.br);
          check({p, "MemRead_cycles"}, c_mrd, e.mrd);
          check({p, "MemWrite_cycles"}, c_mwr, e.mwr);
          check({p, "IORead_cycles"}, c_ird, e.ird);
          check({p, "IOWrite_cycles"}, c_iwr, e.iwr);
          check({p, "instret"}, instret, e.ret);
        end
        mon_idx++;
        active = 0;
      end
    end
  end

  // Issue one instruction; n = extra low cycles of mem_ready/io_ack (n=0: held high throughout).
  task automatic issue(input logic [31:0] ins, input logic [31:0] a7, input int n);
    int k;
    bit done;
    @(negedge clock);
    Instruction = ins; instr_valid = 1'b1; rega7 = a7;
    mem_ready = (n == 0); io_ack = (n == 0);
    @(negedge clock);
    instr_valid = 1'b0;
    k = 0; done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      if (state == 3'd0 || state == 3'd6) begin
        done = 1;
      end else begin
        if (state == 3'd2) rega7 = 32'hFFFF_FFFF;
        if (state == 3'd3 || state == 3'd4) k++;
        mem_ready = (state == 3'd3) ? (k > n) : (n == 0);
        io_ack    = (state == 3'd4) ? (k > n) : (n == 0);
        @(negedge clock);
      end
    end
    mem_ready = 1'b0; io_ack = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got state %0d after 60 cycles, expected FETCH or HALT", state);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] a7, input int n,
                           input exp_t e);
    exp_t x;
    x = e;
    x.ret = exp_ret;
    exp_ret++;
    sb.push_back(x);
    issue(ins, a7, n);
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    sb.delete();
    active = 0;
    exp_ret = 0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; Instruction = '0; instr_valid = 1'b0; rega7 = '0;
    mem_ready = 1'b0; io_ack = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clock); #1;
    check("rst.state", state, 0);
    check("rst.instret", instret, 0);
    check("rst.illegal", illegal, 0);
    check("rst.strobes", {ir_write, pc_write, RegWrite, MemRead, MemWrite, IORead, IOWrite}, 0);
    check("rst.decode", {MemorIOtoReg, Jr, Jal, Branch, I_format, Sftmd, ALUSrc, ALUOp}, 0);

    //                  lat st rw m2r op src sft ifm jal jr br mrd mwr ird iwr
    run_instr(32'h003100B3, 0, 0, mk(4, 5, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // add
    #1 check("hold.ALUOp_in_fetch", ALUOp, 2);
    run_instr(32'h00309093, 0, 0, mk(4, 5, 1, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // slli
    run_instr(32'h0000A083, 0, 3, mk(8, 5, 1, 1, 0, 1, 0, 1, 0, 0, 0, 4, 0, 0, 0)); // lw
    run_instr(32'h0020A023, 0, 0, mk(4, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); // sw
    run_instr(32'h00208063, 0, 0, mk(3, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // beq
    run_instr(32'h000000EF, 0, 0, mk(4, 5, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // jal
    run_instr(32'h000080E7, 0, 0, mk(4, 5, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // jalr
    run_instr(32'h00000073, 2, 2, mk(7, 5, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0)); // ecall rd
    run_instr(32'h00000073, 5, 2, mk(6, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3)); // ecall wr
    run_instr(32'h00000073, 9, 0, mk(3, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // ecall none
    run_instr(32'h000010B7, 0, 0, mk(4, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // lui
    #1;
    check("seq.instret", instret, 11);
    check("seq.sb_empty", sb.size(), 0);

    // Async reset while a load is stalled in MEM.
    @(negedge clock);
    Instruction = 32'h0000A083; instr_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clock);
    instr_valid = 1'b0;
    for (int t = 0; t < 10 && state != 3'd3; t++) @(negedge clock);
    @(negedge clock);
    check("mem.MemRead_before_reset", MemRead, 1);
    async_reset_pulse();
    check("mem.MemRead_async", MemRead, 0);
    check("mem.state_async", state, 0);
    check("mem.instret_async", instret, 0);
    @(negedge clock) rst_n = 1'b1;

    // Illegal opcode halts and stays.
    issue(32'h0000007F, 0, 0);
    #1;
    check("halt.state", state, 6);
    check("halt.illegal", illegal, 1);
    @(negedge clock);
    instr_valid = 1'b1; mem_ready = 1'b1; io_ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clock); #1;
      check("halt.strobes", {ir_write, pc_write, RegWrite, MemRead, MemWrite, IORead, IOWrite}, 0);
    end
    instr_valid = 1'b0; mem_ready = 1'b0; io_ack = 1'b0;
    check("halt.state_held", state, 6);
    check("halt.illegal_held", illegal, 1);
    check("halt.instret", instret, 0);
    async_reset_pulse();
    check("halt.illegal_async", illegal, 0);
    check("halt.state_async", state, 0);
    @(negedge clock) rst_n = 1'b1;

    // Non-ecall system encoding (ebreak) is illegal.
    issue(32'h00100073, 0, 0);
    #1;
    check("ebreak.state", state, 6);
    check("ebreak.illegal", illegal, 1);
    check("ebreak.instret", instret, 0);
    check("end.sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end

endmodule
